// File: rtl/addsub32_seq_ctrl_pkg.sv
// addsub_pkg: shared state encoding and sizing helpers for the sliced add/sub controller
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_DEF = 8;
  function automatic int calc_n(input int width, input int slice);
    return width / slice;
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addsub32_seq_ctrl_add_slice.sv
// add_slice: combinational SLICE-bit adder with carry in/out
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/addsub32_seq_ctrl.sv
// addsub32_seq_ctrl: WIDTH-bit add/subtract computed one SLICE per clock, LSB slice first
module addsub32_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             busy
);
  localparam int N  = calc_n(WIDTH, SLICE);
  localparam int IW = idx_w(N);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic             carry_q, ovf_q;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, last_d, ovf_d;

  assign a_sl   = opa_q[int'(idx_q)*SLICE +: SLICE];
  assign b_sl   = opb_q[int'(idx_q)*SLICE +: SLICE];
  assign last_d = idx_q == IW'(N-1);
  // Only meaningful on the last slice, where sum_sl holds the result MSB
  assign ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) & (sum_sl[SLICE-1] != opa_q[WIDTH-1]);

  add_slice #(.SLICE(SLICE)) u_slice (
    .a(a_sl), .b(b_sl), .cin(carry_q), .s(sum_sl), .cout(cout_sl)
  );

  assign req_ready    = rst_n & ~flush & (state_q == IDLE);
  assign rsp_valid    = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          opa_q    <= req_a;
          opb_q    <= req_b ^ {WIDTH{req_sub}};
          carry_q  <= req_sub;
          idx_q    <= '0;
          result_q <= '0;
          ovf_q    <= 1'b0;
          state_q  <= RUN;
        end
        RUN: begin
          result_q[int'(idx_q)*SLICE +: SLICE] <= sum_sl;
          carry_q <= cout_sl;
          idx_q   <= idx_q + 1'b1;
          if (last_d) begin
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub32_seq_ctrl.sv
// tb_addsub32_seq_ctrl: directed checks of the sliced add/sub controller
module tb_addsub32_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_sub = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_overflow;
  logic        busy;
  int checks = 0;
  int failures = 0;

  addsub32_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clk);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_sub = ~sub;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] r, input logic c, input logic o);
    chk({tag, "_result"}, rsp_result, r);
    chk({tag, "_carry"}, 32'(rsp_carry), 32'(c));
    chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(o));
  endtask

  task automatic ack(input string tag);
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_valid_after_ack"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_after_ack"}, 32'(req_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input logic [31:0] r, input logic c, input logic o);
    issue(a, b, sub);
    wait_done(tag);
    check_rsp(tag, r, c, o);
    ack(tag);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op("t3b", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op("t4", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Backpressure in DONE with a competing request
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("t5");
    req_a = 32'h0000_0010; req_b = 32'h0000_0010; req_sub = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
      check_rsp("t5_hold", 32'h2345_6789, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("t5_second_accept", 32'(busy), 32'd1);
    wait_done("t5b");
    check_rsp("t5b", 32'h0000_0000, 1'b1, 1'b0);
    ack("t5b");

    // Flush after two RUN edges
    issue(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("t6_flush_busy", 32'(busy), 32'd0);
    chk("t6_flush_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    flush = 1'b1; req_valid = 1'b1; req_a = 32'h1; req_b = 32'h1; req_sub = 1'b0;
    #1 chk("t6_flush_gates_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    chk("t6_flush_no_accept", 32'(busy), 32'd0);
    op("t6c", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_valid", 32'(rsp_valid), 32'd0);
    chk("t6r_ready", 32'(req_ready), 32'd0);
    chk("t6r_result", rsp_result, 32'd0);
    chk("t6r_carry", 32'(rsp_carry), 32'd0);
    chk("t6r_ovf", 32'(rsp_overflow), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("t6r_ready_after", 32'(req_ready), 32'd1);
    op("t6d", 32'h0000_000A, 32'h0000_0005, 1'b0, 32'h0000_000F, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
